// File: rtl/ram_burst_reader.sv
// Burst read sequencer for the 16x32 register-file RAM: issues contiguous read
// addresses under a 2-entry credit scheme and streams the returned words out.
module ram_burst_reader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] arg_0_raddr_0,
    input  logic [DATA_WIDTH-1:0] arg_0_rdata_0,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    // state | meaning
    // IDLE  | waiting for start; len 0 completes immediately
    // ISSUE | issuing one read per cycle while credit remains
    // DRAIN | all reads issued; waiting for in-flight data and buffer to empty
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(2 ** ADDR_WIDTH);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   raddr_q;
    logic [LEN_WIDTH-1:0]    remain_q, remain_d;
    logic [LEN_WIDTH-1:0]    len_eff;
    logic                    inflight_q;
    logic                    done_q, done_d;
    logic [DATA_WIDTH-1:0]   buf_q [2];
    logic                    rd_ptr_q, wr_ptr_q;
    logic [1:0]              count_q;
    logic [1:0]              used;
    logic [1:0]              limit;
    logic                    push, pop, issue;

    assign len_eff   = (len > MAX_LEN) ? MAX_LEN : len;

    assign out_valid = (count_q != 2'd0);
    assign out_data  = buf_q[rd_ptr_q];
    assign pop       = out_valid && out_ready;
    assign push      = inflight_q;

    // A word leaving this cycle frees a slot for a read issued this cycle.
    assign used      = count_q + {1'b0, inflight_q};
    assign limit     = pop ? 2'd3 : 2'd2;
    assign issue     = (state_q == ISSUE) && (used < limit);

    assign arg_0_raddr_0 = issue ? addr_q : raddr_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_eff == '0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d   = base_addr;
                        remain_d = len_eff;
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (issue) begin
                    addr_d   = addr_q + 1'b1;
                    remain_d = remain_q - 1'b1;
                    if (remain_q == LEN_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Leave as soon as the final word is being popped.
                if (!inflight_q && (count_q == {1'b0, pop})) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            raddr_q    <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            raddr_q    <= arg_0_raddr_0;
            inflight_q <= issue;
            done_q     <= done_d;
            if (push) begin
                buf_q[wr_ptr_q] <= arg_0_rdata_0;
            end
            wr_ptr_q <= wr_ptr_q ^ push;
            rd_ptr_q <= rd_ptr_q ^ pop;
            count_q  <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: doc/ram_burst_reader.md
Name: ram_burst_reader

Overview:
- Upstream address sequencer for the single-port read side of the 16x32 register-file RAM.
- On a start command it issues a contiguous burst of read addresses on the RAM read port and captures the returned words.
- Captured words are presented on a valid/ready output stream.
- A 2-entry skid buffer absorbs downstream backpressure, so no RAM read result is ever lost or duplicated.

Parameters:
- ADDR_WIDTH, 4, RAM address width; address arithmetic is modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 32, RAM word width.
- LEN_WIDTH, 5, width of the burst length field; holds 0..2^ADDR_WIDTH.

Ports:
- clk  in  1  Clock; all state updates on the rising edge.
- rst  in  1  Synchronous, active-high reset.
- start  in  1  Burst request; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  First RAM address of the burst; sampled with start.
- len  in  LEN_WIDTH  Number of words; values above 16 saturate to 16.
- busy  out  1  High from the cycle after start is accepted until done.
- done  out  1  One-cycle pulse when the burst completes.
- arg_0_raddr_0  out  ADDR_WIDTH  RAM read address.
- arg_0_rdata_0  in  DATA_WIDTH  RAM read data; valid exactly one cycle after the address is presented.
- out_valid  out  1  Output word valid.
- out_ready  in  1  Downstream accepts a word.
- out_data  out  DATA_WIDTH  Output word.

Behaviour:
- Reset: busy=0, done=0, out_valid=0, out_data=0, arg_0_raddr_0=0. Reset also clears the state, counters, skid buffer and in-flight flag.
- Reset asserted mid-burst aborts the burst:
  - the in-flight read is discarded;
  - out_valid is low in the cycle after the reset edge;
  - done is not pulsed.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - start=1 with effective len>0: latch base_addr and len, go to ISSUE, busy=1.
  - start=1 with len=0: stay in IDLE and pulse done in the next cycle; no reads are issued and out_valid never rises.
- ISSUE, one read per cycle when credit allows:
  - credit = 2 - (buffer occupancy + in-flight reads) + (1 if a word is popped this cycle).
  - An issued read drives arg_0_raddr_0 = current address, sets the in-flight flag, increments the address modulo 16 and decrements the remaining count.
  - When the remaining count reaches 0, go to DRAIN.
- DRAIN: wait until in-flight=0 and the buffer is empty; then go to IDLE, pulse done and drop busy.
- Data capture: the cycle after an issue, arg_0_rdata_0 is written into the skid buffer at the clock edge; the in-flight flag clears unless a new read was issued.
- Output:
  - out_valid = buffer not empty; out_data = buffer head.
  - A pop occurs on out_valid && out_ready.
  - Push and pop in the same cycle are both honoured, and occupancy is unchanged.
  - Buffer order is strictly FIFO.
- Latency and throughput:
  - Start is accepted at edge E0; the first address is driven in cycle E0+1.
  - out_valid first rises after edge E0+2.
  - With out_ready held high, throughput is 1 word/cycle.
  - done pulses the cycle after the last word is popped.
- arg_0_raddr_0 holds its last value when no read is issued.
- start while busy is ignored and has no effect on the current burst.
- Wrap-around: addresses wrap 15 -> 0 within a burst.
- The buffer never overflows. A buffer-full condition with a push and no pop is a design error, and the bench asserts on it.

Test Plan:
- RAM preloaded with mem[i]=i*3+1; start with base 2, len 4, out_ready held 1.
  - out_data sequence 7, 10, 13, 16 on consecutive cycles.
  - First out_valid two edges after start; done one cycle after the last beat; busy low after done.
- base 14, len 4.
  - Address sequence 14, 15, 0, 1.
  - Data mem[14], mem[15], mem[0], mem[1].
- base 0, len 8, out_ready toggled 1,0,0,1,0,1... pseudo-randomly.
  - All 8 words are delivered exactly once, in order.
  - No more than 2 reads are outstanding plus buffered at any time.
- len 0: done pulses once in the next cycle; no out_valid; arg_0_raddr_0 unchanged. len 20 behaves exactly as len 16.
- start reasserted mid-burst is ignored and the first burst completes intact. rst asserted after 2 of 6 words: all outputs are at reset values the next cycle, and no done pulse occurs.
